ctrl_seq: RTL and testbench

Sequenced control unit for the 9-bit accumulator ISA; it replaces the purely combinational decoder. It decodes each fetched instruction into register-file, memory, lookup and branch enables. It sequences multi-cycle loads against a parametrised memory latency and holds the fetch unit with `Stall`. It also owns the program start/halt handshake with the testbench. It sits between instruction ROM and the fetch unit, register file, data memory and lookup table.

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/ctrl_decode.sv | 40 ++++
 rtl/ctrl_seq.sv | 139 +++++++++++++
 tb/tb_ctrl_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ctrl_seq sequenced control unit.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } ctrl_state_t;

    localparam int unsigned OP_LOOKUP = 0;
    localparam int unsigned OP_MOVE   = 4;
    localparam int unsigned OP_LOAD   = 5;
    localparam int unsigned OP_STORE  = 6;

    typedef struct packed {
        logic branch;
        logic reg_wr_en;
        logic reg_wr_r0;
        logic mem_wr_en;
        logic mem_rd_en;
        logic load_inst;
        logic lookup;
    } ctrl_en_t;

    // Halt is the all-ones instruction of width w.
    function automatic logic is_halt(input logic [31:0] instr, input int unsigned w);
        for (int i = 0; i < 32; i++) begin
            if (i < w && !instr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational mode/opcode to enable decode for a single-cycle RUN instruction.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            mode,
    input  logic [OP_W-1:0] opcode,
    output ctrl_en_t        en,
    output logic            is_load
);

    localparam logic [OP_W-1:0] OPC_LOOKUP = OP_W'(OP_LOOKUP);
    localparam logic [OP_W-1:0] OPC_MOVE   = OP_W'(OP_MOVE);
    localparam logic [OP_W-1:0] OPC_LOAD   = OP_W'(OP_LOAD);
    localparam logic [OP_W-1:0] OPC_STORE  = OP_W'(OP_STORE);

    // Loads report the single-cycle completion form; the sequencer masks it when waiting.
    always_comb begin
        en      = '0;
        is_load = 1'b0;
        if (mode) begin
            en.branch = 1'b1;
        end else begin
            case (opcode)
                OPC_LOOKUP: en.lookup    = 1'b1;
                OPC_MOVE:   en.reg_wr_en = 1'b1;
                OPC_STORE:  en.mem_wr_en = 1'b1;
                OPC_LOAD: begin
                    en.mem_rd_en = 1'b1;
                    en.reg_wr_r0 = 1'b1;
                    en.load_inst = 1'b1;
                    is_load      = 1'b1;
                end
                default:    en.reg_wr_r0 = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control unit: decode, multi-cycle load stall, start/halt handshake.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int OP_W    = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    output logic               Branch,
    output logic               RegWrEn,
    output logic               RegWrR0,
    output logic               MemWrEn,
    output logic               MemRdEn,
    output logic               LoadInst,
    output logic               Lookup,
    output logic               Stall,
    output logic               Ack,
    output logic [CNT_W-1:0]   InstCount
);

    localparam logic [2:0] LAT_M1 = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

    ctrl_state_t state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    ctrl_en_t    dec_en, en;
    logic        dec_load;
    logic        halt;
    logic        stall;
    logic        ack;

    assign halt = is_halt(32'(Instruction), INSTR_W);

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .mode    (Instruction[INSTR_W-1]),
        .opcode  (Instruction[INSTR_W-2 -: OP_W]),
        .en      (dec_en),
        .is_load (dec_load)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        en      = '0;
        stall   = 1'b1;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DONE;
                end else begin
                    en    = dec_en;
                    stall = 1'b0;
                    if (dec_load && MEM_LAT > 0) begin
                        en.reg_wr_r0 = 1'b0;
                        en.load_inst = 1'b0;
                        stall        = 1'b1;
                        wait_d       = LAT_M1;
                        state_d      = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                en.mem_rd_en = 1'b1;
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    en.reg_wr_r0 = 1'b1;
                    en.load_inst = 1'b1;
                    stall        = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_DONE: begin
                ack = 1'b1;
                if (Start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Branch   = en.branch;
    assign RegWrEn  = en.reg_wr_en;
    assign RegWrR0  = en.reg_wr_r0;
    assign MemWrEn  = en.mem_wr_en;
    assign MemRdEn  = en.mem_rd_en;
    assign LoadInst = en.load_inst;
    assign Lookup   = en.lookup;
    assign Stall    = stall;
    assign Ack      = ack;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic             start_acc;
    logic             retire;

    assign start_acc = Start && (state_q == ST_IDLE || state_q == ST_DONE);
    // The halt cycle retires even though it stalls fetch.
    assign retire    = ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !stall) ||
                       (state_q == ST_RUN && halt);

    always_comb begin
        inst_cnt_d = inst_cnt_q;
        if (start_acc) begin
            inst_cnt_d = '0;
        end else if (retire && inst_cnt_q != {CNT_W{1'b1}}) begin
            inst_cnt_d = inst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) inst_cnt_q <= '0;
        else       inst_cnt_q <= inst_cnt_d;
    end

    assign InstCount = inst_cnt_q;
`else
    assign InstCount = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq; several instances cover different MEM_LAT/CNT_W.
module tb_ctrl_seq;

    localparam int NI = 4;
    localparam int LAT_TAB [NI] = '{2, 0, 3, 1};

`ifdef CTRL_PERF_CNT_EN
    localparam logic [15:0] EXP_CNT = 16'd7;
    localparam logic [1:0]  EXP_SAT = 2'd3;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
    localparam logic [1:0]  EXP_SAT = 2'd0;
`endif

    // obs bit order: Branch RegWrEn RegWrR0 MemWrEn MemRdEn LoadInst Lookup Stall Ack
    localparam logic [8:0] O_IDLE  = 9'b000000010;
    localparam logic [8:0] O_DONE  = 9'b000000011;
    localparam logic [8:0] O_ALU   = 9'b001000000;
    localparam logic [8:0] O_LOOK  = 9'b000000100;
    localparam logic [8:0] O_MOVE  = 9'b010000000;
    localparam logic [8:0] O_STORE = 9'b000100000;
    localparam logic [8:0] O_LD1   = 9'b001011000;
    localparam logic [8:0] O_LDW   = 9'b000010010;
    localparam logic [8:0] O_BR    = 9'b100000000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [8:0] Instruction = 9'h010;

    wire [NI-1:0] br, rwe, r0, mwe, mre, li, lu, st, ak;
    wire [15:0]   cnt [NI];
    wire [8:0]    obs [NI];

    wire        s_br, s_rwe, s_r0, s_mwe, s_mre, s_li, s_lu, s_st, s_ak;
    wire [1:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ctrl_seq #(.INSTR_W(9), .OP_W(4), .MEM_LAT(LAT_TAB[g]), .CNT_W(16)) u_dut (
            .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
            .Branch(br[g]), .RegWrEn(rwe[g]), .RegWrR0(r0[g]), .MemWrEn(mwe[g]),
            .MemRdEn(mre[g]), .LoadInst(li[g]), .Lookup(lu[g]), .Stall(st[g]),
            .Ack(ak[g]), .InstCount(cnt[g])
        );
        assign obs[g] = {br[g], rwe[g], r0[g], mwe[g], mre[g], li[g], lu[g], st[g], ak[g]};
    end

    ctrl_seq #(.INSTR_W(9), .OP_W(4), .MEM_LAT(1), .CNT_W(2)) u_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
        .Branch(s_br), .RegWrEn(s_rwe), .RegWrR0(s_r0), .MemWrEn(s_mwe),
        .MemRdEn(s_mre), .LoadInst(s_li), .Lookup(s_lu), .Stall(s_st),
        .Ack(s_ak), .InstCount(s_cnt)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic restart();
        Reset = 1'b1;
        Start = 1'b0;
        step();
        Reset = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        step();
        step();
        Reset = 1'b0;
        Start = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== O_IDLE) begin
                failures++;
                $display("FAIL reset_outs[%0d] got=%b exp=%b", i, obs[i], O_IDLE);
            end
            checks++;
            if (cnt[i] !== 16'd0) begin
                failures++;
                $display("FAIL reset_cnt[%0d] got=%0d exp=0", i, cnt[i]);
            end
        end
        step();
        checks++;
        if (obs[0] !== O_IDLE) begin
            failures++;
            $display("FAIL idle_hold got=%b exp=%b", obs[0], O_IDLE);
        end
    endtask

    task automatic test_start();
        Instruction = 9'h010;
        Start = 1'b1;
        step();
        Start = 1'b0;
        #1;
        checks++;
        if (obs[0] !== O_ALU) begin
            failures++;
            $display("FAIL start_run got=%b exp=%b", obs[0], O_ALU);
        end
    endtask

    task automatic test_opcodes();
        logic [8:0] exp;
        logic [8:0] br_vec [2];
        br_vec[0] = 9'h123;
        br_vec[1] = 9'h1FE;
        restart();
        for (int op = 0; op < 16; op++) begin
            Instruction = {1'b0, 4'(op), 4'h5};
            case (op)
                0:       exp = O_LOOK;
                4:       exp = O_MOVE;
                5:       exp = O_LD1;
                6:       exp = O_STORE;
                default: exp = O_ALU;
            endcase
            #1;
            checks++;
            if (obs[1] !== exp) begin
                failures++;
                $display("FAIL opcode_%0d got=%b exp=%b", op, obs[1], exp);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            Instruction = br_vec[k];
            #1;
            checks++;
            if (obs[1] !== O_BR) begin
                failures++;
                $display("FAIL branch_%h got=%b exp=%b", br_vec[k], obs[1], O_BR);
            end
            step();
        end
    endtask

    task automatic test_load();
        logic [8:0] exp_l2 [3];
        exp_l2[0] = O_LDW;
        exp_l2[1] = O_LDW;
        exp_l2[2] = O_LD1;
        restart();
        Instruction = 9'h050;
        #1;
        checks++;
        if (obs[1] !== O_LD1) begin
            failures++;
            $display("FAIL load_lat0 got=%b exp=%b", obs[1], O_LD1);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs[0] !== exp_l2[c]) begin
                failures++;
                $display("FAIL load_lat2_cyc%0d got=%b exp=%b", c + 1, obs[0], exp_l2[c]);
            end
            step();
        end
        Instruction = 9'h010;
        #1;
        checks++;
        if (obs[0] !== O_ALU) begin
            failures++;
            $display("FAIL load_after got=%b exp=%b", obs[0], O_ALU);
        end
        step();
    endtask

    task automatic test_halt();
        restart();
        Instruction = 9'h1FF;
        #1;
        checks++;
        if (obs[0] !== O_IDLE) begin
            failures++;
            $display("FAIL halt_cycle got=%b exp=%b", obs[0], O_IDLE);
        end
        step();
        checks++;
        if (obs[0] !== O_DONE) begin
            failures++;
            $display("FAIL done_ack got=%b exp=%b", obs[0], O_DONE);
        end
        step();
        checks++;
        if (obs[0] !== O_DONE) begin
            failures++;
            $display("FAIL done_hold got=%b exp=%b", obs[0], O_DONE);
        end
        Start = 1'b1;
        Instruction = 9'h010;
        step();
        Start = 1'b0;
        #1;
        checks++;
        if (obs[0] !== O_ALU) begin
            failures++;
            $display("FAIL done_restart got=%b exp=%b", obs[0], O_ALU);
        end
        // Start in RUN is ignored.
        Start = 1'b1;
        step();
        Start = 1'b0;
        #1;
        checks++;
        if (obs[0] !== O_ALU) begin
            failures++;
            $display("FAIL start_in_run got=%b exp=%b", obs[0], O_ALU);
        end
    endtask

    task automatic test_reset_mid_load();
        restart();
        Instruction = 9'h050;
        #1;
        checks++;
        if (obs[2] !== O_LDW) begin
            failures++;
            $display("FAIL lat3_cyc1 got=%b exp=%b", obs[2], O_LDW);
        end
        step();
        Reset = 1'b1;
        #1;
        checks++;
        if (obs[2] !== O_LDW) begin
            failures++;
            $display("FAIL lat3_cyc2 got=%b exp=%b", obs[2], O_LDW);
        end
        step();
        Reset = 1'b0;
        #1;
        checks++;
        if (obs[2] !== O_IDLE) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=%b", obs[2], O_IDLE);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (r0[2] !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_r0 cyc=%0d got=%b exp=0", c, r0[2]);
            end
        end
    endtask

    task automatic test_perf_cnt();
        logic [8:0] alu [5];
        alu[0] = 9'h010; alu[1] = 9'h020; alu[2] = 9'h030; alu[3] = 9'h070; alu[4] = 9'h0A0;
        restart();
        for (int k = 0; k < 5; k++) begin
            Instruction = alu[k];
            step();
        end
        Instruction = 9'h050;
        step();
        step();
        Instruction = 9'h1FF;
        step();
        checks++;
        if (obs[3] !== O_DONE) begin
            failures++;
            $display("FAIL perf_done got=%b exp=%b", obs[3], O_DONE);
        end
        checks++;
        if (cnt[3] !== EXP_CNT) begin
            failures++;
            $display("FAIL perf_count got=%0d exp=%0d", cnt[3], EXP_CNT);
        end
        checks++;
        if (s_cnt !== EXP_SAT) begin
            failures++;
            $display("FAIL perf_sat got=%0d exp=%0d", s_cnt, EXP_SAT);
        end
        step();
        checks++;
        if (cnt[3] !== EXP_CNT) begin
            failures++;
            $display("FAIL perf_hold got=%0d exp=%0d", cnt[3], EXP_CNT);
        end
        Start = 1'b1;
        Instruction = 9'h010;
        step();
        Start = 1'b0;
        checks++;
        if (cnt[3] !== 16'd0) begin
            failures++;
            $display("FAIL perf_clear got=%0d exp=0", cnt[3]);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_opcodes();
        test_load();
        test_halt();
        test_reset_mid_load();
        test_perf_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
